jk_bank_ctrl: RTL and testbench

Command sequencer for a WIDTH-bit bank of JK flip-flops sharing this block's clock and reset. It accepts one command at a time over a valid/ready handshake and drives the bank's J/K inputs to load, set, clear, toggle or count. It checks the bank's Q outputs against an internal shadow value after every step. It sits between a host/test controller and the jkflipflop instances, replacing hand-driven J/K stimulus.

---
 rtl/jk_bank_ctrl_if.sv | 26 ++
 rtl/jk_bank_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_jk_bank_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jk_bank_ctrl_if.sv
// Command/status bundle between a host and jk_bank_ctrl.
// The host drives the command fields; the controller returns the handshake and status.
interface jk_bank_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 8
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic [CNTW-1:0]  cmd_steps;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] value;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, cmd_steps,
    input  cmd_ready, busy, done, err, value
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, cmd_steps,
    output cmd_ready, busy, done, err, value
  );
endinterface

// File: rtl/jk_bank_ctrl.sv
// Sequencer driving the J/K inputs of a bank of JK flip-flops, one command at a time,
// verifying the bank's Q outputs against a shadow copy after every applied step.
module jk_bank_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  jk_bank_ctrl_if.slave    cmd,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q
);

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_CLEAR  = 3'd2;
  localparam logic [2:0] OP_SET    = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;
  localparam logic [2:0] OP_UP     = 3'd5;
  localparam logic [2:0] OP_DOWN   = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  state_e           state_reg;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] arg_reg;
  logic [CNTW-1:0]  steps_reg;
  logic [WIDTH-1:0] shadow_reg;
  logic [WIDTH-1:0] j_reg;
  logic [WIDTH-1:0] k_reg;
  logic             done_reg;
  logic             err_reg;

  logic [2:0]       src_op;
  logic [WIDTH-1:0] src_arg;
  logic [WIDTH-1:0] pat_j;
  logic [WIDTH-1:0] pat_k;
  logic [WIDTH-1:0] shadow_next;
  logic [WIDTH-1:0] up_mask;
  logic [WIDTH-1:0] dn_mask;
  logic             cmd_is_count;
  logic             cmd_is_noop;

  // Bit i toggles on increment when every lower bit is 1, on decrement when every lower bit is 0.
  assign up_mask[0] = 1'b1;
  assign dn_mask[0] = 1'b1;
  for (genvar gi = 1; gi < WIDTH; gi++) begin : g_chain
    assign up_mask[gi] = &shadow_reg[gi-1:0];
    assign dn_mask[gi] = &(~shadow_reg[gi-1:0]);
  end

  // The first step is built from the incoming command, later steps from the captured one.
  assign src_op  = (state_reg == ST_IDLE) ? cmd.cmd_op  : op_reg;
  assign src_arg = (state_reg == ST_IDLE) ? cmd.cmd_arg : arg_reg;

  always_comb begin
    pat_j = '0;
    pat_k = '0;
    case (src_op)
      OP_LOAD: begin
        pat_j = src_arg;
        pat_k = ~src_arg;
      end
      OP_CLEAR: pat_k = '1;
      OP_SET:   pat_j = '1;
      OP_TOGGLE: begin
        pat_j = src_arg;
        pat_k = src_arg;
      end
      OP_UP: begin
        pat_j = up_mask;
        pat_k = up_mask;
      end
      OP_DOWN: begin
        pat_j = dn_mask;
        pat_k = dn_mask;
      end
      default: begin
        pat_j = '0;
        pat_k = '0;
      end
    endcase
  end

  always_comb begin
    shadow_next = shadow_reg;
    case (op_reg)
      OP_LOAD:   shadow_next = arg_reg;
      OP_CLEAR:  shadow_next = '0;
      OP_SET:    shadow_next = '1;
      OP_TOGGLE: shadow_next = shadow_reg ^ arg_reg;
      OP_UP:     shadow_next = shadow_reg + WIDTH'(1);
      OP_DOWN:   shadow_next = shadow_reg - WIDTH'(1);
      default:   shadow_next = shadow_reg;
    endcase
  end

  assign cmd_is_count = (cmd.cmd_op == OP_UP) || (cmd.cmd_op == OP_DOWN);
  assign cmd_is_noop  = (cmd.cmd_op == OP_NOP) || (cmd.cmd_op == 3'd7) ||
                        (cmd_is_count && (cmd.cmd_steps == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      op_reg     <= OP_NOP;
      arg_reg    <= '0;
      steps_reg  <= '0;
      shadow_reg <= '0;
      j_reg      <= '0;
      k_reg      <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      // Drives default to "hold" so J/K are nonzero only while in APPLY.
      j_reg    <= '0;
      k_reg    <= '0;
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cmd.cmd_valid) begin
            op_reg  <= cmd.cmd_op;
            arg_reg <= cmd.cmd_arg;
            err_reg <= 1'b0;
            if (cmd_is_noop) begin
              state_reg <= ST_FIN;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_APPLY;
              j_reg     <= pat_j;
              k_reg     <= pat_k;
              steps_reg <= cmd_is_count ? cmd.cmd_steps : CNTW'(1);
            end
          end
        end
        ST_APPLY: begin
          shadow_reg <= shadow_next;
          state_reg  <= ST_CHECK;
        end
        ST_CHECK: begin
          if (q != shadow_reg) begin
            // Resynchronise to what the bank really holds and abandon the rest.
            err_reg    <= 1'b1;
            shadow_reg <= q;
            state_reg  <= ST_FIN;
            done_reg   <= 1'b1;
          end else if (steps_reg > CNTW'(1)) begin
            steps_reg <= steps_reg - CNTW'(1);
            j_reg     <= pat_j;
            k_reg     <= pat_k;
            state_reg <= ST_APPLY;
          end else begin
            state_reg <= ST_FIN;
            done_reg  <= 1'b1;
          end
        end
        ST_FIN: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd.cmd_ready = (state_reg == ST_IDLE) && !reset;
  assign cmd.busy      = (state_reg != ST_IDLE);
  assign cmd.done      = done_reg;
  assign cmd.err       = err_reg;
  assign cmd.value     = shadow_reg;
  assign j             = j_reg;
  assign k             = k_reg;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Scoreboard bench for jk_bank_ctrl: a behavioural JK bank with injectable stuck-at-0 bits,
// a command-level reference model feeding expectation queues, and a monitor that checks them.
module tb_jk_bank_ctrl;
  localparam int WIDTH = 4;
  localparam int CNTW  = 8;
  localparam logic [WIDTH-1:0] ONES = '1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] j, k, q;
  logic [WIDTH-1:0] bank_q;
  logic [WIDTH-1:0] stuck = '0;
  int               cyc = 0;

  jk_bank_ctrl_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

  jk_bank_ctrl #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .cmd   (bus.slave),
    .j     (j),
    .k     (k),
    .q     (q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural bank: Q+ = J~Q | ~K Q, with stuck bits forced low.
  always @(posedge clk) begin
    if (reset) bank_q <= '0;
    else       bank_q <= ((j & ~bank_q) | (~k & bank_q)) & ~stuck;
  end
  assign q = bank_q;

  typedef struct {
    int               cyc;
    logic [WIDTH-1:0] value;
    logic             err;
  } done_t;

  typedef struct {
    int               cyc;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
  } jk_t;

  done_t done_q[$];
  jk_t   jk_q[$];
  int    tests = 0;
  int    fails = 0;
  logic [WIDTH-1:0] m_val  = '0;  // what the controller should believe
  logic [WIDTH-1:0] m_bank = '0;  // what the bank really holds

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Command-level reference: arithmetic on the bank value, J/K = bits that must change.
  task automatic model(input logic [2:0] op, input logic [WIDTH-1:0] arg,
                       input logic [CNTW-1:0] steps, input int acc);
    int n;
    logic [WIDTH-1:0] tgt, pj, pk, nb;
    if (op == 3'd0 || op == 3'd7 || ((op == 3'd5 || op == 3'd6) && steps == '0)) begin
      done_q.push_back('{acc + 1, m_val, 1'b0});
      return;
    end
    n = (op == 3'd5 || op == 3'd6) ? int'(steps) : 1;
    for (int s = 1; s <= n; s++) begin
      case (op)
        3'd1:    begin tgt = arg;          pj = arg;  pk = ~arg; end
        3'd2:    begin tgt = '0;           pj = '0;   pk = ONES; end
        3'd3:    begin tgt = ONES;         pj = ONES; pk = '0;   end
        3'd4:    begin tgt = m_val ^ arg;  pj = arg;  pk = arg;  end
        3'd5:    begin tgt = m_val + WIDTH'(1); pj = m_val ^ tgt; pk = pj; end
        default: begin tgt = m_val - WIDTH'(1); pj = m_val ^ tgt; pk = pj; end
      endcase
      jk_q.push_back('{acc + 2*s - 1, pj, pk});
      nb = ((pj & ~m_bank) | (~pk & m_bank)) & ~stuck;
      m_bank = nb;
      if (nb != tgt) begin
        m_val = nb;
        done_q.push_back('{acc + 2*s + 1, m_val, 1'b1});
        return;
      end
      m_val = tgt;
    end
    done_q.push_back('{acc + 2*n + 1, m_val, 1'b0});
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] arg,
                       input logic [CNTW-1:0] steps, input bit hold);
    int guard = 0;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready) begin
      bus.cmd_op    = 3'($urandom);
      bus.cmd_arg   = WIDTH'($urandom);
      bus.cmd_steps = CNTW'($urandom);
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        check("ready_timeout", 32'd0, 32'd1);
        bus.cmd_valid = 1'b0;
        return;
      end
    end
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    bus.cmd_steps = steps;
    model(op, arg, steps, cyc);
    @(negedge clk);
    // Busy now: keep valid up with junk fields, which must be ignored.
    bus.cmd_valid = hold;
    bus.cmd_op    = 3'($urandom);
    bus.cmd_arg   = WIDTH'($urandom);
    bus.cmd_steps = CNTW'($urandom);
  endtask

  task automatic quiesce();
    int guard = 0;
    bus.cmd_valid = 1'b0;
    while (!(bus.cmd_ready && done_q.size() == 0)) begin
      @(negedge clk);
      guard++;
      if (guard > 300) begin
        check("quiesce_timeout", 32'd0, 32'd1);
        done_q.delete();
        jk_q.delete();
        return;
      end
    end
  endtask

  task automatic set_stuck(input logic [WIDTH-1:0] mask);
    stuck  = mask;
    m_bank = m_bank & ~mask;
  endtask

  // Monitor: pops the scoreboard whenever the DUT shows done or an APPLY is due.
  always @(negedge clk) begin
    if (!reset) begin
      while (jk_q.size() > 0 && jk_q[0].cyc < cyc) begin
        check("apply_missed", 32'(cyc), 32'(jk_q[0].cyc));
        void'(jk_q.pop_front());
      end
      if (jk_q.size() > 0 && jk_q[0].cyc == cyc) begin
        check("j_pattern", 32'(j), 32'(jk_q[0].j));
        check("k_pattern", 32'(k), 32'(jk_q[0].k));
        void'(jk_q.pop_front());
      end else begin
        check("jk_zero_outside_apply", 32'({j, k}), 32'd0);
      end
      while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
        check("done_missed", 32'(cyc), 32'(done_q[0].cyc));
        void'(done_q.pop_front());
      end
      if (bus.done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          check("done_cycle", 32'(cyc), 32'(done_q[0].cyc));
          check("value", 32'(bus.value), 32'(done_q[0].value));
          check("err", 32'(bus.err), 32'(done_q[0].err));
          $display("[TB] done cyc=%0d value=%h err=%b", cyc, bus.value, bus.err);
          void'(done_q.pop_front());
        end
      end
      check("busy_vs_ready", 32'(bus.busy), 32'(!bus.cmd_ready));
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int guard;
    logic [2:0]       op;
    logic [WIDTH-1:0] arg;
    logic [CNTW-1:0]  steps;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_arg   = '0;
    bus.cmd_steps = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_jk", 32'({j, k}), 32'd0);
    check("rst_status", 32'({bus.busy, bus.done, bus.err}), 32'd0);
    check("rst_value", 32'(bus.value), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.cmd_ready), 32'd1);

    // Directed scenarios.
    issue(3'd1, 4'b1010, 8'd0, 1'b0); quiesce();
    issue(3'd1, 4'hE, 8'd0, 1'b0);    quiesce();
    issue(3'd5, 4'h0, 8'd3, 1'b0);    quiesce();
    issue(3'd2, 4'h0, 8'd0, 1'b0);    quiesce();
    issue(3'd6, 4'h0, 8'd2, 1'b0);    quiesce();
    issue(3'd1, 4'b1010, 8'd0, 1'b1);
    issue(3'd4, 4'b0110, 8'd0, 1'b1);
    issue(3'd2, 4'h0, 8'd0, 1'b1);
    issue(3'd3, 4'h0, 8'd0, 1'b1);
    issue(3'd0, 4'h5, 8'd9, 1'b1);
    issue(3'd7, 4'h5, 8'd9, 1'b1);
    issue(3'd5, 4'h0, 8'd0, 1'b0);    quiesce();

    // Bit 2 stuck low while counting up from zero.
    issue(3'd2, 4'h0, 8'd0, 1'b0);    quiesce();
    set_stuck(4'b0100);
    issue(3'd5, 4'h0, 8'd8, 1'b0);    quiesce();
    set_stuck('0);

    // Reset during the CHECK of a multi-step count.
    issue(3'd1, 4'h3, 8'd0, 1'b0);    quiesce();
    issue(3'd5, 4'h0, 8'd5, 1'b0);
    acc = cyc - 1;
    guard = 0;
    while (cyc < acc + 2 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    reset = 1'b1;
    done_q.delete();
    jk_q.delete();
    @(negedge clk);
    check("midrst_jk", 32'({j, k}), 32'd0);
    check("midrst_value", 32'(bus.value), 32'd0);
    check("midrst_status", 32'({bus.cmd_ready, bus.busy, bus.done, bus.err}), 32'd0);
    reset = 1'b0;
    m_val  = '0;
    m_bank = '0;
    @(negedge clk);
    issue(3'd1, 4'b1001, 8'd0, 1'b0); quiesce();

    // Randomized traffic with occasional stuck bits.
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        quiesce();
        if ($urandom_range(0, 1) == 1) set_stuck(WIDTH'(1) << $urandom_range(0, WIDTH-1));
        else                           set_stuck('0);
      end
      op    = 3'($urandom_range(0, 7));
      arg   = WIDTH'($urandom);
      steps = CNTW'($urandom_range(0, 10));
      issue(op, arg, steps, 1'($urandom_range(0, 1)));
    end
    quiesce();
    set_stuck('0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(done_q.size() + jk_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
